// File: rtl/output_port_buffer_pkg.sv
// ----------------------------------------------------------------------------
// RouterPkg
// Shared router types: the 32-bit packet format carried across the crossbar,
// the number of link bytes per packet, and the output-buffer serializer state.
// ----------------------------------------------------------------------------
package RouterPkg;

    // Packet layout, MSB first: {src, dest} forms the first byte on the link.
    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    localparam int PKT_BYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ob_state_t;

endpackage

// File: rtl/output_port_buffer_fifo.sv
// ----------------------------------------------------------------------------
// pkt_fifo
// Synchronous DEPTH-entry packet FIFO with a combinational head.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   we, wdata    : write strobe and packet (ignored when full)
//   re           : pop strobe (ignored when empty)
//   rdata        : packet at the head, valid whenever count != 0
//   count        : number of packets held
// ----------------------------------------------------------------------------
module pkt_fifo
    import RouterPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  pkt_t                   wdata,
    input  logic                   re,
    output pkt_t                   rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    pkt_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic               full_s;
    logic               empty_s;
    logic               do_wr_s;
    logic               do_rd_s;

    assign full_s  = (count_r == (PTR_W + 1)'(DEPTH));
    assign empty_s = (count_r == (PTR_W + 1)'(0));
    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_wr_s = we && !full_s;
    assign do_rd_s = re && !empty_s;

    assign rdata = mem[rd_ptr_r];
    assign count = count_r;

    // Storage write; pushes on a reset edge are dropped.
    always_ff @(posedge clock) begin
        if (do_wr_s && !reset) begin
            mem[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/output_port_buffer.sv
// ----------------------------------------------------------------------------
// output_port_buffer
// Buffers whole packets from one crossbar output and serializes each onto the
// 8-bit outbound link, MSB byte first, one byte per accepted cycle.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   pkt_in            : packet from the crossbar output
//   pkt_in_avail      : pkt_in valid this cycle
//   ob_ready_to_recv  : a packet can be accepted this cycle (register decode)
//   put_outbound      : payload_outbound carries a valid byte
//   payload_outbound  : current outbound byte
//   free_outbound     : downstream takes the byte this cycle
//   occupancy         : packets waiting in the FIFO (not the one in flight)
// ----------------------------------------------------------------------------
module output_port_buffer
    import RouterPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  pkt_t                   pkt_in,
    input  logic                   pkt_in_avail,
    output logic                   ob_ready_to_recv,
    output logic                   put_outbound,
    output logic [7:0]             payload_outbound,
    input  logic                   free_outbound,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int        CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [1:0] LAST_IDX = 2'(PKT_BYTES - 1);

    ob_state_t        state_r;
    logic [31:0]      shift_r;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] count_s;
    pkt_t             head_s;
    logic             push_s;
    logic             pop_s;

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .we    (push_s),
        .wdata (pkt_in),
        .re    (pop_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Ready depends only on the registered count, never on the inputs.
    assign ob_ready_to_recv = (count_s != CNT_W'(DEPTH));
    assign push_s           = pkt_in_avail && ob_ready_to_recv;
    assign occupancy        = count_s;
    assign put_outbound     = (state_r == SEND);
    assign payload_outbound = shift_r[31:24];

    // Pop decision: load when idle, or chain the next packet on the last byte.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_s != CNT_W'(0)) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            SEND: begin
                if (free_outbound && (idx_r == LAST_IDX) && (count_s != CNT_W'(0))) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Serializer FSM with shift register and byte index.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= 32'h0000_0000;
            idx_r   <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r <= head_s;
                        idx_r   <= 2'd0;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (free_outbound) begin
                        if (pop_s) begin
                            // Back-to-back packet: no idle cycle between bursts.
                            shift_r <= head_s;
                            idx_r   <= 2'd0;
                        end else begin
                            // After the last byte the register drains to zero.
                            shift_r <= {shift_r[23:0], 8'h00};
                            idx_r   <= idx_r + 2'd1;
                            if (idx_r == LAST_IDX) begin
                                state_r <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shift_r <= 32'h0000_0000;
                    idx_r   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_buffer.sv
// ----------------------------------------------------------------------------
// tb_output_port_buffer
// Drives output_port_buffer with directed and random traffic and compares every
// cycle against a packet-queue model of the buffer and its serializer.
// ----------------------------------------------------------------------------
module tb_output_port_buffer;
    import RouterPkg::*;

    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    pkt_t          pkt_in;
    logic          pkt_in_avail;
    logic          ob_ready_to_recv;
    logic          put_outbound;
    logic [7:0]    payload_outbound;
    logic          free_outbound;
    logic [OW-1:0] occupancy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: waiting packets, packet in flight, bytes still to send.
    logic [31:0] q[$];
    logic [31:0] cur = 32'h0;
    int          rem = 0;

    output_port_buffer #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_in           (pkt_in),
        .pkt_in_avail     (pkt_in_avail),
        .ob_ready_to_recv (ob_ready_to_recv),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .free_outbound    (free_outbound),
        .occupancy        (occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_byte();
        if (rem == 0) return 8'h00;
        return 8'(cur >> (8 * (rem - 1)));
    endfunction

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input logic a, input logic [31:0] p, input logic f, input logic r);
        bit acc;
        int presize;
        pkt_in       = pkt_t'(p);
        pkt_in_avail = a;
        free_outbound = f;
        reset        = r;
        @(posedge clock);
        if (r) begin
            q.delete();
            rem = 0;
            cur = 32'h0;
        end else begin
            presize = q.size();
            acc     = a && (presize != DEPTH);
            if (rem == 0) begin
                if (presize != 0) begin
                    cur = q.pop_front();
                    rem = PKT_BYTES;
                end
            end else if (f) begin
                rem--;
                if (rem == 0 && presize != 0) begin
                    cur = q.pop_front();
                    rem = PKT_BYTES;
                end
            end
            if (acc) q.push_back(p);
        end
        #1;
        chk("put",       32'(put_outbound),     32'(rem != 0));
        chk("payload",   32'(payload_outbound), 32'(model_byte()));
        chk("occupancy", 32'(occupancy),        32'(q.size()));
        chk("ready",     32'(ob_ready_to_recv), 32'(q.size() != DEPTH));
    endtask

    initial begin
        pkt_in        = '0;
        pkt_in_avail  = 1'b0;
        free_outbound = 1'b0;
        reset         = 1'b1;

        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst_put",   32'(put_outbound),     32'h0);
        chk("rst_pay",   32'(payload_outbound), 32'h0);
        chk("rst_occ",   32'(occupancy),        32'h0);
        chk("rst_ready", 32'(ob_ready_to_recv), 32'h1);

        // Single packet, free held high
        step(1'b1, 32'h12AB_CDEF, 1'b1, 1'b0);
        chk("single_nobypass", 32'(put_outbound), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("single_b0", 32'(payload_outbound), 32'h12);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("single_b1", 32'(payload_outbound), 32'hAB);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("single_b2", 32'(payload_outbound), 32'hCD);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("single_b3", 32'(payload_outbound), 32'hEF);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("single_done", 32'(put_outbound), 32'h0);

        // Backpressure after byte 1
        step(1'b1, 32'h12AB_CDEF, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            chk("stall_hold", 32'(payload_outbound), 32'hAB);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stall_b2", 32'(payload_outbound), 32'hCD);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stall_b3", 32'(payload_outbound), 32'hEF);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill: 5 pushes with the link stalled, 6th ignored
        for (int i = 0; i < 6; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
        chk("fill_occ",   32'(occupancy),        32'h4);
        chk("fill_ready", 32'(ob_ready_to_recv), 32'h0);
        for (int i = 0; i < 22; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Burst of 3 queued packets
        for (int i = 0; i < 3; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous push and pop at occupancy 2
        for (int i = 0; i < 3; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, $urandom(), 1'b1, 1'b0);
        chk("pushpop_occ", 32'(occupancy), 32'h2);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic: exercises pointer wrap and concurrent push/pop
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 3) != 0, 1'b0);
        end
        for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset mid-packet after byte 1, with a push on the reset edge
        step(1'b1, 32'h3344_5566, 1'b0, 1'b0);
        step(1'b1, 32'h7788_99AA, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("midrst_put",   32'(put_outbound),     32'h0);
        chk("midrst_occ",   32'(occupancy),        32'h0);
        chk("midrst_ready", 32'(ob_ready_to_recv), 32'h1);
        step(1'b1, 32'h5A01_0203, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("midrst_new_b0", 32'(payload_outbound), 32'h5A);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
